// File: rtl/game_sequencer.sv
// Pong game-flow controller: attract/serve/play/pause/point/game-over sequencing and score keeping.
// Optional PLAY<->PAUSE toggling on the start key is compiled in with PONG_PAUSE_EN.
module game_sequencer #(
    parameter int SERVE_TICKS = 60,
    parameter int POINT_TICKS = 30,
    parameter int WIN_SCORE   = 7,
    parameter int CNT_W       = 8
) (
    input  logic       CLOCK_25,
    input  logic       reset_n,
    input  logic       tick,
    input  logic [3:0] keys_1,
    input  logic [3:0] keys_2,
    input  logic       miss_1,
    input  logic       miss_2,
    output logic       run,
    output logic       serve,
    output logic       serve_dir,
    output logic [2:0] score_1,
    output logic [2:0] score_2,
    output logic [2:0] state,
    output logic [1:0] winner
);

    localparam logic [2:0] ST_ATTRACT  = 3'd0;
    localparam logic [2:0] ST_SERVE    = 3'd1;
    localparam logic [2:0] ST_PLAY     = 3'd2;
    localparam logic [2:0] ST_PAUSE    = 3'd3;
    localparam logic [2:0] ST_POINT    = 3'd4;
    localparam logic [2:0] ST_GAMEOVER = 3'd5;

    localparam logic [3:0]       KEY_START = 4'd5;
    localparam logic [CNT_W-1:0] SERVE_CNT = CNT_W'(SERVE_TICKS);
    localparam logic [CNT_W-1:0] POINT_CNT = CNT_W'(POINT_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [2:0]       WIN_VAL   = 3'(WIN_SCORE);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_prev_q, key_prev_d;
    logic             key_armed_q, key_armed_d;
    logic             serve_entry_q, serve_entry_d;
    logic             serve_q, serve_d;
    logic             run_q, run_d;
    logic             serve_dir_q, serve_dir_d;
    logic [2:0]       score_1_q, score_1_d;
    logic [2:0]       score_2_q, score_2_d;
    logic [1:0]       winner_q, winner_d;

    logic start_now;
    logic start_ev;

    // A key held through reset must be seen released on a tick before it can start a game.
    assign start_now   = (keys_1 == KEY_START) || (keys_2 == KEY_START);
    assign start_ev    = tick && start_now && !key_prev_q && key_armed_q;
    assign key_prev_d  = tick ? start_now : key_prev_q;
    assign key_armed_d = key_armed_q | (tick & ~start_now);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        serve_dir_d = serve_dir_q;
        score_1_d   = score_1_q;
        score_2_d   = score_2_q;
        winner_d    = winner_q;

        case (state_q)
            ST_ATTRACT, ST_GAMEOVER: begin
                if (start_ev) begin
                    state_d     = ST_SERVE;
                    cnt_d       = SERVE_CNT;
                    score_1_d   = 3'd0;
                    score_2_d   = 3'd0;
                    winner_d    = 2'd0;
                    serve_dir_d = 1'b0;
                end
            end
            ST_SERVE: begin
                if (tick) begin
                    if (cnt_q <= CNT_ONE) begin
                        state_d = ST_PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            ST_PLAY: begin
                if (miss_1) begin
                    score_2_d   = score_2_q + 3'd1;
                    serve_dir_d = 1'b1;
                    state_d     = ST_POINT;
                    cnt_d       = POINT_CNT;
                end else if (miss_2) begin
                    score_1_d   = score_1_q + 3'd1;
                    serve_dir_d = 1'b0;
                    state_d     = ST_POINT;
                    cnt_d       = POINT_CNT;
                end
`ifdef PONG_PAUSE_EN
                else if (start_ev) begin
                    state_d = ST_PAUSE;
                end
`endif
            end
`ifdef PONG_PAUSE_EN
            ST_PAUSE: begin
                if (start_ev) begin
                    state_d = ST_PLAY;
                end
            end
`endif
            ST_POINT: begin
                if (tick) begin
                    if (cnt_q <= CNT_ONE) begin
                        if (score_1_q == WIN_VAL) begin
                            winner_d = 2'd1;
                            state_d  = ST_GAMEOVER;
                            cnt_d    = '0;
                        end else if (score_2_q == WIN_VAL) begin
                            winner_d = 2'd2;
                            state_d  = ST_GAMEOVER;
                            cnt_d    = '0;
                        end else begin
                            state_d = ST_SERVE;
                            cnt_d   = SERVE_CNT;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_ATTRACT;
                cnt_d   = '0;
            end
        endcase
    end

    // serve_entry marks the first SERVE cycle; serve fires one cycle later.
    assign serve_entry_d = (state_d == ST_SERVE) && (state_q != ST_SERVE);
    assign serve_d       = serve_entry_q;
    assign run_d         = (state_d == ST_PLAY);

    always_ff @(posedge CLOCK_25 or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_ATTRACT;
            cnt_q         <= '0;
            key_prev_q    <= 1'b0;
            key_armed_q   <= 1'b0;
            serve_entry_q <= 1'b0;
            serve_q       <= 1'b0;
            run_q         <= 1'b0;
            serve_dir_q   <= 1'b0;
            score_1_q     <= 3'd0;
            score_2_q     <= 3'd0;
            winner_q      <= 2'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            key_prev_q    <= key_prev_d;
            key_armed_q   <= key_armed_d;
            serve_entry_q <= serve_entry_d;
            serve_q       <= serve_d;
            run_q         <= run_d;
            serve_dir_q   <= serve_dir_d;
            score_1_q     <= score_1_d;
            score_2_q     <= score_2_d;
            winner_q      <= winner_d;
        end
    end

    assign run       = run_q;
    assign serve     = serve_q;
    assign serve_dir = serve_dir_q;
    assign score_1   = score_1_q;
    assign score_2   = score_2_q;
    assign state     = state_q;
    assign winner    = winner_q;

endmodule
